// File: rtl/muxn_pipe.sv
// muxn_pipe: registered N-to-1 channel multiplexer with valid/ready handshake.
//
// Each accepted offer captures channel[sel] of the packed input bus into a
// single output register. A select outside 0..NUM_IN-1 captures all zeros
// and raises sel_err for the cycle after acceptance.
//
// Build option (macro SKID_BUF_EN):
//   undefined : in_ready = !out_valid || out_ready (combinational), no skid.
//   defined   : one skid entry absorbs an item arriving during an output
//               stall; in_ready = !skid_full, driven from a register.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    NUM_IN packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel        channel select, sampled with in_data
//   in_valid   upstream offer
//   in_ready   offer accepted this cycle (when in_valid=1 and flush=0)
//   flush      synchronous kill of all buffered items; blocks acceptance
//   out_data   registered selected channel
//   out_valid  out_data holds an item
//   out_ready  downstream consumes out_data
//   sel_err    one-cycle pulse after accepting an out-of-range select
module muxn_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_ok;
    logic             w_in_xfer;

    // Unmatched selects leave w_sel_data at zero, which is the required
    // capture value for an out-of-range channel.
    always_comb begin
        w_sel_data = '0;
        w_sel_ok   = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
                w_sel_ok   = 1'b1;
            end
        end
    end

    assign w_in_xfer = in_valid && in_ready && !flush;

`ifdef SKID_BUF_EN
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             w_load_ok;

    assign in_ready  = !r_skid_valid;
    assign w_load_ok = !r_out_valid || out_ready;

    // While the skid entry is full in_ready is 0, so a skid drain and a new
    // acceptance never happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_sel_err    <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_sel_err <= w_in_xfer && !w_sel_ok;
            if (w_load_ok) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_out_data  <= w_sel_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_xfer) begin
                r_skid_data  <= w_sel_data;
                r_skid_valid <= 1'b1;
            end
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_sel_err <= w_in_xfer && !w_sel_ok;
            if (w_in_xfer) begin
                r_out_data  <= w_sel_data;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_muxn_pipe.sv
// Testbench for muxn_pipe: directed vectors on a 4-channel and a 3-channel
// instance, followed by a randomized handshake run against a queue model.
// Expectations follow the build option SKID_BUF_EN when it is defined.
module tb_muxn_pipe;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [127:0] in_data;
    logic [1:0]   sel;
    logic         in_valid, in_ready, flush;
    logic [31:0]  out_data;
    logic         out_valid, out_ready, sel_err;

    logic [95:0]  in_data3;
    logic [1:0]   sel3;
    logic         in_valid3, in_ready3, flush3;
    logic [31:0]  out_data3;
    logic         out_valid3, out_ready3, sel_err3;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [31:0]  q[$];

    always #5 clk = ~clk;

    muxn_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    muxn_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sel_err(sel_err3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One random-handshake cycle, entered and left at posedge+1.
    task automatic rnd_cycle(input bit iv, input bit ordy, output bit xo);
        logic [31:0] pd;
        bit          stall, xi;
        in_valid  = iv;
        out_ready = ordy;
        if (iv) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            sel     = 2'($urandom_range(3));
        end
        @(negedge clk);
        xi    = in_valid && in_ready;
        xo    = out_valid && out_ready;
        stall = out_valid && !out_ready;
        pd    = out_data;
        if (xo) begin
            chk("rnd_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) chk("rnd_order", out_data, q.pop_front());
        end
        if (xi) q.push_back(in_data[sel*32 +: 32]);
        @(posedge clk);
        #1;
        if (stall) begin
            chk("rnd_hold_data", out_data, pd);
            chk("rnd_hold_valid", out_valid, 1);
        end
    endtask

    initial begin
        int ntx;
        int cyc;
        bit xo;

        rst_n     = 1'b0;
        in_data   = '0; sel  = '0; in_valid  = 1'b0; flush  = 1'b0; out_ready  = 1'b0;
        in_data3  = '0; sel3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_out_valid3", out_valid3, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Back-to-back selects 0..3 at full throughput
        in_data   = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            chk("seq_data", out_data, 64'h1000_0000 + 64'(i));
            chk("seq_valid", out_valid, 1);
            chk("seq_sel_err", sel_err, 0);
        end
        in_valid = 1'b0;
        step();
        chk("seq_empty", out_valid, 0);

        // Capture then stall for 5 cycles while inputs toggle
        in_data   = {96'h0, 32'hDEAD_BEEF};
        sel       = 2'd0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        chk("stall_cap_data", out_data, 32'hDEAD_BEEF);
        for (int j = 0; j < 5; j++) begin
            in_data = {32'h5A5A_0000 + 32'(j), 64'h0, 32'hA5A5_0000 + 32'(j)};
            sel     = 2'(j % 2 == 0 ? 0 : 3);
`ifdef SKID_BUF_EN
            chk("stall_in_ready", in_ready, (j == 0) ? 1 : 0);
`else
            chk("stall_in_ready", in_ready, 0);
`endif
            step();
            chk("stall_data", out_data, 32'hDEAD_BEEF);
            chk("stall_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
`ifdef SKID_BUF_EN
        chk("drain_skid_data", out_data, 32'hA5A5_0000);
        chk("drain_skid_valid", out_valid, 1);
        step();
`endif
        chk("drain_empty", out_valid, 0);

        // Stalled output plus a second offer, then flush with an offer pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        in_data   = {64'h0, 32'h0000_0A01, 32'h0};
        step();
        chk("fl_first", out_data, 32'h0000_0A01);
        in_data   = {64'h0, 32'h0000_0A02, 32'h0};
        step();
        chk("fl_in_ready", in_ready, 0);
        in_data   = {64'h0, 32'h0000_0A03, 32'h0};
        flush     = 1'b1;
        step();
        chk("fl_valid", out_valid, 0);
        chk("fl_in_ready_after", in_ready, 1);
        chk("fl_sel_err", sel_err, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("fl_nothing_out", out_valid, 0);
        end

        // Out-of-range select on the 3-channel instance
        in_data3   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        sel3       = 2'd2;
        step();
        chk("oor_ok_data", out_data3, 32'h3333_3333);
        chk("oor_ok_err", sel_err3, 0);
        sel3 = 2'd3;
        step();
        chk("oor_data", out_data3, 0);
        chk("oor_valid", out_valid3, 1);
        chk("oor_err", sel_err3, 1);
        sel3 = 2'd0;
        step();
        chk("oor_err_pulse", sel_err3, 0);
        chk("oor_next_data", out_data3, 32'h1111_1111);
        sel3   = 2'd3;
        flush3 = 1'b1;
        step();
        chk("oor_flush_err", sel_err3, 0);
        chk("oor_flush_valid", out_valid3, 0);
        flush3    = 1'b0;
        in_valid3 = 1'b0;

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd2;
        in_data   = {32'h0, 32'h1234_5678, 64'h0};
        step();
        chk("ar_loaded", out_valid, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_clear", out_valid, 0);
        chk("ar_data_clear", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", in_ready, 1);
        in_data   = {64'h0, 32'hCAFE_0001, 32'h0};
        sel       = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar_first_data", out_data, 32'hCAFE_0001);
        chk("ar_first_valid", out_valid, 1);
        in_valid = 1'b0;
        step();

        // Random handshake run against the queue model
        ntx = 0;
        cyc = 0;
        q.delete();
        while (ntx < 10000 && cyc < 80000) begin
            rnd_cycle(1'($urandom_range(1)), 1'($urandom_range(1)), xo);
            cyc++;
            if (xo) ntx++;
        end
        chk("rnd_count", ntx, 10000);
        for (int i = 0; i < 4; i++) rnd_cycle(1'b0, 1'b1, xo);
        chk("rnd_drain_q", q.size(), 0);
        chk("rnd_drain_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
